// File: rtl/pos_link_pkg.sv
// Shared definitions for the single-link player-position protocol.
// Frame byte layout: B0 sync, B1..B3 the packed position, B4 the XOR of B1..B3.
package pos_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 5;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_GET1   = 3'd1,
    ST_GET2   = 3'd2,
    ST_GET3   = 3'd3,
    ST_GETCHK = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  level;
  } pos_t;

  // Payload bytes as {B1, B2, B3}, B1 in the top byte.
  function automatic logic [23:0] pack_pos(input pos_t p);
    return {p.x[7:0], p.y[4:0], p.x[10:8], p.level, p.y[10:5]};
  endfunction

  function automatic pos_t unpack_pos(input logic [23:0] f);
    pos_t p;
    p.x     = {f[10:8], f[23:16]};
    p.y     = {f[5:0], f[15:11]};
    p.level = f[7:6];
    return p;
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Saturating cycle counter with synchronous clear; the reset value can be
// either zero or already saturated.
module link_watchdog #(
  parameter int MAX_COUNT = 100,
  parameter bit RESET_SAT = 1'b0,
  parameter int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_V = W'(MAX_COUNT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RESET_SAT ? MAX_V : '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX_V)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pos_frame_rx.sv
// Receive deframer: hunts for the sync byte, collects one frame, verifies the
// XOR checksum and publishes the remote position; tracks presence and errors.
module pos_frame_rx
  import pos_link_pkg::*;
#(
  parameter int GAP_CYCLES     = 100_000,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] remote_x,
  output logic [11:0] remote_y,
  output logic [1:0]  remote_level,
  output logic        remote_valid,
  output logic        remote_present,
  output logic [7:0]  err_count,
  output rx_state_t   dbg_state
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the cycle the counter would reach GAP_CYCLES, so a byte
  // arriving after exactly GAP_CYCLES idle cycles already finds the FSM in HUNT.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PRES_MAX = PW'(TIMEOUT_CYCLES);

  rx_state_t r_state, w_next;

  logic [7:0]    r_s1, r_s2, r_s3;
  logic [10:0]   r_x, r_y;
  logic [1:0]    r_level;
  logic          r_valid;
  logic [7:0]    r_err;

  logic          w_in_frame, w_gap_expire;
  logic          w_store1, w_store2, w_store3, w_chk_strobe, w_good, w_bad;
  logic [GW-1:0] w_gap_cnt;
  logic [PW-1:0] w_pres_cnt;
  pos_t          w_pos;

  link_watchdog #(.MAX_COUNT(GAP_CYCLES), .RESET_SAT(1'b0), .W(GW)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (rx_valid || (r_state == ST_HUNT)),
    .i_en    (w_in_frame),
    .o_count (w_gap_cnt)
  );

  link_watchdog #(.MAX_COUNT(TIMEOUT_CYCLES), .RESET_SAT(1'b1), .W(PW)) u_presence (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_good),
    .i_en    (1'b1),
    .o_count (w_pres_cnt)
  );

  assign w_in_frame   = (r_state != ST_HUNT);
  assign w_gap_expire = w_in_frame && !rx_valid && (w_gap_cnt >= GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HUNT:   if (rx_valid && (rx_data == SYNC_BYTE)) w_next = ST_GET1;
      ST_GET1:   if (rx_valid) w_next = ST_GET2;   else if (w_gap_expire) w_next = ST_HUNT;
      ST_GET2:   if (rx_valid) w_next = ST_GET3;   else if (w_gap_expire) w_next = ST_HUNT;
      ST_GET3:   if (rx_valid) w_next = ST_GETCHK; else if (w_gap_expire) w_next = ST_HUNT;
      ST_GETCHK: if (rx_valid || w_gap_expire) w_next = ST_HUNT;
      default:   w_next = ST_HUNT;
    endcase
  end

  always_comb begin
    w_store1     = 1'b0;
    w_store2     = 1'b0;
    w_store3     = 1'b0;
    w_chk_strobe = 1'b0;
    case (r_state)
      ST_GET1:   w_store1     = rx_valid;
      ST_GET2:   w_store2     = rx_valid;
      ST_GET3:   w_store3     = rx_valid;
      ST_GETCHK: w_chk_strobe = rx_valid;
      default:   ;
    endcase
    w_good = w_chk_strobe && (rx_data == (r_s1 ^ r_s2 ^ r_s3));
    w_bad  = w_chk_strobe && (rx_data != (r_s1 ^ r_s2 ^ r_s3));
  end

  assign w_pos = unpack_pos({r_s1, r_s2, r_s3});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_err   <= '0;
    end else begin
      r_valid <= w_good;
      if (w_store1) r_s1 <= rx_data;
      if (w_store2) r_s2 <= rx_data;
      if (w_store3) r_s3 <= rx_data;
      if (w_good) begin
        r_x     <= w_pos.x;
        r_y     <= w_pos.y;
        r_level <= w_pos.level;
      end
      if (w_bad && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  assign remote_x       = {1'b0, r_x};
  assign remote_y       = {1'b0, r_y};
  assign remote_level   = r_level;
  assign remote_valid   = r_valid;
  assign remote_present = (w_pres_cnt < PRES_MAX);
  assign err_count      = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_pos_frame_rx.sv
// Bench for pos_frame_rx: directed protocol cases plus random framed traffic,
// checked every cycle against a byte-queue reference model.
module tb_pos_frame_rx;
  import pos_link_pkg::*;

  localparam int GAP = 20;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] remote_x, remote_y;
  logic [1:0]  remote_level;
  logic        remote_valid, remote_present;
  logic [7:0]  err_count;
  rx_state_t   dbg_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pos_frame_rx #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .remote_x       (remote_x),
    .remote_y       (remote_y),
    .remote_level   (remote_level),
    .remote_valid   (remote_valid),
    .remote_present (remote_present),
    .err_count      (err_count),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame bytes collected in a queue, gaps and presence
  // judged from absolute cycle numbers.
  logic [7:0]  m_buf[$];
  logic [23:0] exp_q[$];
  longint      cyc = 0, last_byte_cyc = 0, good_cyc = 0;
  bit          have_good = 1'b0;
  logic [10:0] m_x = '0, m_y = '0;
  logic [1:0]  m_lvl = '0;
  logic        m_valid = 1'b0;
  int          m_err = 0;

  task automatic model_byte(input logic [7:0] b);
    if (m_buf.size() > 0 && (cyc - last_byte_cyc - 1) >= GAP) m_buf.delete();
    last_byte_cyc = cyc;
    if (m_buf.size() == 0) begin
      if (b == 8'hA5) m_buf.push_back(b);
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 5) begin
        if ((m_buf[1] ^ m_buf[2] ^ m_buf[3]) == m_buf[4]) begin
          m_x   = {m_buf[2][2:0], m_buf[1]};
          m_y   = {m_buf[3][5:0], m_buf[2][7:3]};
          m_lvl = m_buf[3][7:6];
          m_valid   = 1'b1;
          good_cyc  = cyc;
          have_good = 1'b1;
          exp_q.push_back({m_x, m_y, m_lvl});
        end else if (m_err < 255) begin
          m_err++;
        end
        m_buf.delete();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    m_valid = 1'b0;
    if (rst) begin
      m_buf.delete();
      exp_q.delete();
      have_good = 1'b0;
      m_x = '0; m_y = '0; m_lvl = '0; m_err = 0;
    end else if (rx_valid) begin
      model_byte(rx_data);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic m_present;
      logic [23:0] exp_pos;
      m_present = have_good && ((cyc - good_cyc) < TMO);
      check("outputs",
            {28'd0, remote_x, remote_y, remote_level, remote_valid, remote_present, err_count},
            {28'd0, 1'b0, m_x, 1'b0, m_y, m_lvl, m_valid, m_present, 8'(m_err)});
      if (remote_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          exp_pos = exp_q.pop_front();
          check("scoreboard", {40'd0, remote_x[10:0], remote_y[10:0], remote_level}, {40'd0, exp_pos});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int x, input int y, input int l, input bit bad, input int gap_max);
    logic [7:0] b[5];
    b[0] = 8'hA5;
    b[1] = 8'(x % 256);
    b[2] = 8'(((y % 32) * 8) + (x / 256));
    b[3] = 8'((l * 64) + (y / 32));
    b[4] = b[1] ^ b[2] ^ b[3];
    if (bad) b[4] = b[4] ^ 8'(1 << $urandom_range(7, 0));
    for (int i = 0; i < 5; i++) begin
      send_byte(b[i]);
      if (i < 4 && gap_max > 0) idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish before 2ms");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_x", remote_x, 0);
    check("reset_valid", remote_valid, 0);
    check("reset_present", remote_present, 0);
    check("reset_err", err_count, 0);
    check("reset_state", dbg_state, ST_HUNT);
    rst = 1'b0;
    idle(2);

    // Good frame on consecutive strobes
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h62); send_byte(8'h89); send_byte(8'h6B);
    check("good_valid", remote_valid, 1);
    check("good_x", remote_x, 640);
    check("good_y", remote_y, 300);
    check("good_level", remote_level, 2);
    check("good_present", remote_present, 1);
    idle(1);
    check("pulse_width", remote_valid, 0);

    // Bad checksum, then a different good frame
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h62); send_byte(8'h89); send_byte(8'h6C);
    check("bad_err", err_count, 1);
    check("bad_no_pulse", remote_valid, 0);
    check("bad_hold_x", remote_x, 640);
    send_frame(5, 7, 1, 1'b0, 0);
    check("next_good_x", remote_x, 5);
    check("next_good_y", remote_y, 7);

    // Garbage before sync
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h62); send_byte(8'h89); send_byte(8'h6B);
    check("garbage_x", remote_x, 640);
    check("garbage_level", remote_level, 2);

    // Sync value inside the payload is data
    send_frame(933, 1000, 3, 1'b0, 0);
    check("a5_data_x", remote_x, 933);
    check("a5_data_y", remote_y, 1000);

    // Gap abort at exactly GAP idle cycles; one fewer is tolerated
    send_byte(8'hA5); send_byte(8'h80); idle(GAP);
    send_byte(8'h62); send_byte(8'h89); send_byte(8'h6B);
    check("gap_abort_x", remote_x, 933);
    send_byte(8'hA5); send_byte(8'h80); idle(GAP - 1);
    send_byte(8'h62); send_byte(8'h89); send_byte(8'h6B);
    check("gap_edge_x", remote_x, 640);

    // Presence drops exactly TMO cycles after the pulse
    idle(TMO - 1);
    check("present_before", remote_present, 1);
    idle(1);
    check("present_after", remote_present, 0);
    check("present_hold_x", remote_x, 640);

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h62);
    pulse_reset();
    send_byte(8'h89); send_byte(8'h6B);
    idle(1);
    check("midreset_x", remote_x, 0);
    check("midreset_state", dbg_state, ST_HUNT);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_frame(i, i, 1, 1'b1, 0);
    check("err_saturated", err_count, 255);

    // Random traffic
    pulse_reset();
    for (int i = 0; i < 150; i++) begin
      int ng;
      ng = $urandom_range(2, 0);
      for (int g = 0; g < ng; g++) send_byte(8'($urandom_range(255, 0)));
      if ($urandom_range(9, 0) == 0) begin
        send_byte(8'hA5); send_byte(8'($urandom_range(255, 0)));
        idle($urandom_range(GAP + 1, GAP - 1));
      end
      send_frame($urandom_range(2047, 0), $urandom_range(2047, 0), $urandom_range(3, 0),
                 ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0) ? GAP + 1 : 3);
      idle($urandom_range(3, 0));
    end
    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_frame_rx.md
# pos_frame_rx

Receive-side deframer for the single-link player-position protocol. It consumes bytes from a UART receiver (`rx_data`/`rx_valid`) and hunts for the sync byte. It collects one 5-byte frame, checks its XOR checksum and publishes the remote player's x, y and level to the remote-character drawing path. It also tracks link presence and counts corrupted frames, so a silent or noisy link is detectable instead of drawing garbage.

## Interface
Parameters:
- `GAP_CYCLES`, default 100_000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- `TIMEOUT_CYCLES`, default 10_000_000: cycles without a good frame before `remote_present` drops.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (`clk100` domain)
- `rst`  in  1  synchronous active-high reset
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle
- `remote_x`  out  12  remote x position, 11-bit value, bit 11 always 0
- `remote_y`  out  12  remote y position, 11-bit value, bit 11 always 0
- `remote_level`  out  2  remote level
- `remote_valid`  out  1  one-cycle pulse when the outputs have just been updated
- `remote_present`  out  1  high while good frames arrive within `TIMEOUT_CYCLES`
- `err_count`  out  8  count of checksum failures, saturating

## Operation
Frame format, in byte order:
- B0 = sync `0xA5`
- B1 = x[7:0]
- B2 = {y[4:0], x[10:8]}
- B3 = {level[1:0], y[10:5]}
- B4 = B1 ^ B2 ^ B3

FSM states: HUNT, GET1, GET2, GET3, GETCHK.

Transitions:
- HUNT: `rx_valid` with `0xA5` moves to GET1. Any other byte is ignored.
- GET1/GET2/GET3: `rx_valid` stores the byte into shadow register s1/s2/s3 and advances.
- GETCHK: `rx_valid` compares the byte with s1^s2^s3.
  - Match: load the outputs from the shadow registers, pulse `remote_valid`, clear the presence timer, return to HUNT.
  - Mismatch: `err_count` += 1 (holds at 255), outputs unchanged, return to HUNT.

Rules:
- Inside GET1..GETCHK, `0xA5` is ordinary data. There is no resync mid-frame.
- Gap counter:
  - Resets on every `rx_valid`.
  - Counts only in GET1..GETCHK.
  - Reaching `GAP_CYCLES` returns the FSM to HUNT. No error count, outputs unchanged.
- Presence timer:
  - Counts every cycle and saturates at `TIMEOUT_CYCLES`.
  - `remote_present` = (timer < `TIMEOUT_CYCLES`).
  - Cleared on a good frame.
- Outputs hold their last good value when the link is lost. Consumers gate on `remote_present`.

## Timing
- Reset values:
  - State HUNT.
  - `remote_x` = `remote_y` = 0, `remote_level` = 0.
  - `remote_valid` = 0, `err_count` = 0.
  - `remote_present` = 0, because the timer resets to saturated.
  - Shadow registers and gap counter = 0.
- Latency: the outputs and the `remote_valid` pulse are registered and visible on the cycle after the `rx_valid` cycle of B4.
- `remote_valid` is exactly 1 cycle wide. There are no back-to-back pulses closer than 5 `rx_valid` strobes.
- `rx_valid` may be asserted on consecutive cycles; every strobe is consumed.
- A gap abort and an `rx_valid` in the same cycle: the byte wins and the gap counter clears.
- `rst` asserted mid-frame discards the partial frame. The next cycle starts in HUNT with all outputs at their reset values.
- `err_count` saturates at 255 and never wraps.

## Structure
- Package `pos_link_pkg`:
  - `SYNC_BYTE = 8'hA5`
  - `FRAME_LEN = 5`
  - `typedef enum logic [2:0]` for the FSM states
  - a `pack_pos`/`unpack_pos` function pair, reused by the future transmit framer
- Sub-module `link_watchdog`: a parameterised saturating cycle counter with clear, used for both the gap counter and the presence timer.
- Everything else stays in `pos_frame_rx`.

## Test plan
- Good frame: A5 80 62 89 6B on consecutive strobes -> one cycle after the last byte, `remote_x`=640, `remote_y`=300, `remote_level`=2, one `remote_valid` pulse, `remote_present`=1.
- Bad checksum: A5 80 62 89 6C -> outputs unchanged, `err_count` goes 0->1, no `remote_valid` pulse, the next good frame is accepted.
- Garbage before sync: 11 22 A5 80 62 89 6B -> same result as the good-frame case. A frame whose B1 = A5 is still decoded as data (x[7:0]=0xA5).
- Gap abort: A5 80, idle `GAP_CYCLES`, then 62 89 6B -> no update. Then A5 80 62 89 6B -> update.
- Presence: after one good frame, idle `TIMEOUT_CYCLES` (use 1000 in the bench) -> `remote_present` falls exactly at `TIMEOUT_CYCLES` cycles after the `remote_valid` pulse, while the outputs hold their values.
- Reset mid-frame plus saturation: `rst` after A5 80 62 -> the trailing 89 6B produce no update. 300 bad frames -> `err_count`=255.
